// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter.
package uart_arb_pkg;
  localparam int MAX_REQ = 8;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_ACK,
    WAIT_DONE
  } uart_arb_state_e;

  // Explicit wrap so non-power-of-2 requester counts stay in range.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, with wrap.
module rr_arbiter #(
  parameter  int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);
  function automatic int slot(input int p, input int k);
    int s;
    s = p + k;
    return (s >= N) ? s - N : s;
  endfunction

  // Scan from the farthest offset down so the nearest one to ptr wins last.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[slot(int'(ptr), k)]) begin
        gnt_idx   = W'(slot(int'(ptr), k));
        gnt_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART TX core among NUM_REQ byte streams.
// Optional stall revocation is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ        = 2,
  parameter  int TIMEOUT_CYCLES = 100000,
  localparam int GW             = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [GW-1:0]        grant_id,
  output logic                 arb_busy,
  output logic                 timeout_pulse
);
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  uart_arb_state_e r_state;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   r_grant;
  logic            r_last;
  logic            r_tx_start;
  logic            r_arb_busy;
  logic            r_timeout;
  uart_byte_t      r_tx_data;

  logic [GW-1:0]   w_pick;
  logic            w_pick_vld;
  logic            w_own_vld;
  logic            w_timeout_hit;
  logic [GW-1:0]   w_next_ptr;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (r_rr_ptr),
    .gnt_idx   (w_pick),
    .gnt_valid (w_pick_vld)
  );

  assign w_own_vld  = req_valid[r_grant];
  assign w_next_ptr = GW'(wrap_inc(int'(r_grant), NUM_REQ));

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;

  // Fires on the last permitted LOAD cycle; the pulse is seen as the count reaches the limit.
  assign w_timeout_hit = (r_state == LOAD) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_to_cnt <= '0;
    else          r_to_cnt <= (r_state == LOAD) ? r_to_cnt + 1'b1 : '0;
  end
`else
  assign w_timeout_hit = 1'b0;
`endif

  always_comb begin
    req_ready = '0;
    if (r_state == LOAD && !w_timeout_hit) req_ready[r_grant] = w_own_vld;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_last     <= 1'b0;
      r_tx_start <= 1'b0;
      r_arb_busy <= 1'b0;
      r_timeout  <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_start <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_vld && !tx_busy) begin
            r_grant    <= w_pick;
            r_arb_busy <= 1'b1;
            r_state    <= LOAD;
          end
        end
        LOAD: begin
          if (w_timeout_hit) begin
            r_timeout  <= 1'b1;
            r_rr_ptr   <= w_next_ptr;
            r_arb_busy <= 1'b0;
            r_state    <= IDLE;
          end else if (w_own_vld) begin
            r_tx_data  <= req_data[{r_grant, 3'b000} +: 8];
            r_last     <= req_last[r_grant];
            r_tx_start <= 1'b1;
            r_state    <= START;
          end
        end
        START:    r_state <= WAIT_ACK;
        WAIT_ACK: if (tx_busy) r_state <= WAIT_DONE;
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (r_last) begin
              r_rr_ptr   <= w_next_ptr;
              r_arb_busy <= 1'b0;
              r_state    <= IDLE;
            end else begin
              r_state    <= LOAD;
            end
          end
        end
        default: begin
          r_arb_busy <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign tx_start      = r_tx_start;
  assign tx_data       = r_tx_data;
  assign grant_id      = r_grant;
  assign arb_busy      = r_arb_busy;
  assign timeout_pulse = r_timeout;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single on-board UART transmitter (driving `txd`) between `NUM_REQ` byte-stream requesters, such as the CPU's MMIO UART port and a debug/trace unit. It grants the transmitter round-robin and locks the grant for a whole packet, up to and including the requester's `last` byte. It sequences each byte into the UART TX core through a start/busy handshake, sitting between the requesters and the UART TX core inside `thinpad_top`.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2..8).
- `TIMEOUT_CYCLES`, 100000: stall limit for `UART_ARB_TIMEOUT_EN`, in clk cycles (1 ms at 100 MHz).

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  requester i has a byte.
- `req_data`  in  NUM_REQ*8  byte of requester i, at bits [8i+7:8i].
- `req_last`  in  NUM_REQ  byte is the last of the packet.
- `req_ready`  out  NUM_REQ  byte of requester i accepted this cycle; one-hot or zero.
- `tx_start`  out  1  one-cycle pulse to the UART TX core.
- `tx_data`  out  8  byte to send; stable from `tx_start` until the next load.
- `tx_busy`  in  1  UART TX core is shifting.
- `grant_id`  out  $clog2(NUM_REQ)  current or last owner.
- `arb_busy`  out  1  a packet is in progress (state ≠ IDLE).
- `timeout_pulse`  out  1  one-cycle pulse when a stalled grant is revoked.

## Operation
- Handshake: a byte transfers when `req_valid[i] && req_ready[i]`.
  - Requesters hold `req_data` and `req_last` stable while valid.
  - `req_ready` depends combinationally on state, grant and `req_valid`.
- **IDLE:** if `|req_valid && !tx_busy`, select the first valid index searching from `rr_ptr` upward with wrap. Register it into `grant_id`, then go to LOAD. Otherwise stay.
- **LOAD:**
  - If `req_valid[grant_id]`: assert `req_ready[grant_id]`, register the byte into `tx_data` and `req_last` into `last_q`, then go to START.
  - Otherwise stay; the owner is stalled mid-packet and other requesters are not served.
- **START:** `tx_start`=1 for exactly one cycle, then go to WAIT_ACK.
- **WAIT_ACK:** wait for `tx_busy`=1, then go to WAIT_DONE.
- **WAIT_DONE:** wait for `tx_busy`=0.
  - If `last_q`: set `rr_ptr` = `grant_id`+1 (mod `NUM_REQ`) and go to IDLE.
  - Otherwise go to LOAD.
- Fairness: the owner of the packet just finished has lowest priority at the next arbitration.
- Simultaneous requests in IDLE: the lowest index at or above `rr_ptr` (with wrap) wins; the others wait with no loss of data.
- `req_valid` of non-owners is ignored while `arb_busy`.
- `rr_ptr` wrap: `NUM_REQ`-1 + 1 → 0. For non-power-of-2 `NUM_REQ`, compare explicitly; do not rely on bit truncation.
- Reset mid-packet: the packet is abandoned, with no `tx_start` after reset. A byte already handed to the UART core finishes in that core.

## Timing
- Reset values:
  - `req_ready`=0, `tx_start`=0, `tx_data`=8'h00, `grant_id`=0, `arb_busy`=0, `timeout_pulse`=0.
  - State IDLE, `rr_ptr`=0, `last_q`=0.
- Grant latency: `req_valid` seen in IDLE at cycle 0 → LOAD at cycle 1 → `req_ready` at cycle 1 (if still valid) → `tx_start` at cycle 2.
- Per-byte overhead beyond the UART frame: 3 cycles (LOAD, START, WAIT_ACK≥1). Next `req_ready` comes 1 cycle after `tx_busy` falls.
- `arb_busy` is high from cycle 1 until the cycle after the last byte's `tx_busy` falls.
- All outputs except `req_ready` are registered.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter (width $clog2(TIMEOUT_CYCLES+1)) counts cycles in LOAD and clears on leaving LOAD.
  - On reaching `TIMEOUT_CYCLES`: pulse `timeout_pulse` for 1 cycle, set `rr_ptr` = `grant_id`+1 and go to IDLE. No byte is accepted in that cycle.
- Not defined: no counter is built, `timeout_pulse` is tied 0, and the grant is held indefinitely.

## Structure
- `uart_arb_pkg`: state enum `uart_arb_state_e` {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE}, `MAX_REQ`=8 and byte type `uart_byte_t`.
- Sub-module `rr_arbiter #(N)`: combinational round-robin pick (`req`, `ptr` → `gnt_idx`, `gnt_valid`). It is reusable for the future MMIO bus arbiter.
- The top level holds the FSM, the data/last registers and the optional timeout counter.

## Test plan
- **Single byte:** req0 valid with data 8'h41 and last=1, UART model sets busy 1 cycle after start for 10 cycles.
  - Expect `tx_start` 2 cycles after valid, `tx_data`=8'h41 and `req_ready[0]` one pulse.
  - Expect IDLE 1 cycle after busy falls, and `rr_ptr`=1.
- **Collision with packet lock:** req0 sends 3 bytes (8'h01,02,03; last on 03) while req1 holds 8'hAA valid.
  - Expect UART order 01,02,03,AA, with no interleaving.
- **Round-robin:** both requesters stream continuous 1-byte packets.
  - Expect alternating grants 0,1,0,1 and equal counts ±1 over 20 packets.
- **Reset mid-packet:** assert `reset_n`=0 during WAIT_DONE of byte 2.
  - Expect all outputs at reset values immediately, and no `tx_start` until a new request after release.
- **Timeout** (`UART_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): req0 drops valid after its non-last first byte while req1 is valid.
  - Expect `timeout_pulse` after 16 LOAD cycles, then req1 granted on the next arbitration.
  - Without the macro, req1 is never granted.
- **NUM_REQ=3 wrap:** owner 2 finishes with requesters 0 and 1 valid.
  - Expect the grant to go to 0.
